// File: rtl/press_arbiter_if.sv
// Button/arm inputs and result outputs of the tug-of-war press arbiter.
// The master drives the raw buttons and clr; the slave (arbiter) drives the result strobes.
interface press_arbiter_if;
    logic pbl;
    logic pbr;
    logic clr;
    logic winrnd;
    logic right;
    logic tie;

    modport master (
        output pbl,
        output pbr,
        output clr,
        input  winrnd,
        input  right,
        input  tie
    );

    modport slave (
        input  pbl,
        input  pbr,
        input  clr,
        output winrnd,
        output right,
        output tie
    );
endinterface

// File: rtl/press_arbiter.sv
// Synchronizes and debounces both pushbuttons, then decides first press / tie for an armed round.
// Emits one registered winrnd (with right) or tie strobe per round.
module press_arbiter #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIE_WINDOW      = 8
) (
    input logic            clk,
    input logic            rst,
    press_arbiter_if.slave bus
);
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned WinW = (TIE_WINDOW > 0) ? $clog2(TIE_WINDOW + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);
    localparam logic [WinW-1:0] WinMax = WinW'(TIE_WINDOW);

    typedef enum logic [1:0] {StIdle, StArmed, StWindow, StResult} state_e;

    // Bit 0 is the left button, bit 1 the right button.
    logic [1:0]      raw;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      lvl_q, lvl_d;
    logic [1:0]      ev_d, ev_q;
    logic [CntW-1:0] cnt_q [2];
    logic [CntW-1:0] cnt_d [2];

    state_e          state_q, state_d;
    logic [WinW-1:0] win_q, win_d;
    logic            tie_flag_q, tie_flag_d;
    logic            first_q, first_d;
    logic            winrnd_q, winrnd_d;
    logic            right_q, right_d;
    logic            tie_q, tie_d;
    logic            tie_nx;

    assign raw = {bus.pbr, bus.pbl};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lvl_d[i] = lvl_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    lvl_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        ev_d = lvl_d & ~lvl_q;
    end

    // ARMED reacts to the edge the press event is registered on; WINDOW looks at registered events.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        tie_flag_d = tie_flag_q;
        first_d    = first_q;
        winrnd_d   = 1'b0;
        right_d    = right_q;
        tie_d      = 1'b0;
        tie_nx     = tie_flag_q;
        unique case (state_q)
            StIdle: ;
            StArmed: begin
                if (ev_d != 2'b00) begin
                    state_d    = StWindow;
                    win_d      = '0;
                    tie_flag_d = &ev_d;
                    first_d    = ev_d[1] & ~ev_d[0];
                end
            end
            StWindow: begin
                tie_nx     = tie_flag_q | (first_q ? ev_q[0] : ev_q[1]);
                tie_flag_d = tie_nx;
                win_d      = win_q + 1'b1;
                if (win_q == WinMax) begin
                    state_d = StResult;
                    win_d   = '0;
                    if (tie_nx) begin
                        tie_d   = 1'b1;
                        right_d = 1'b0;
                    end else begin
                        winrnd_d = 1'b1;
                        right_d  = first_q;
                    end
                end
            end
            StResult: begin
                state_d    = StIdle;
                tie_flag_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase
        if (bus.clr) begin
            state_d    = StArmed;
            win_d      = '0;
            tie_flag_d = 1'b0;
            first_d    = 1'b0;
            winrnd_d   = 1'b0;
            tie_d      = 1'b0;
            right_d    = right_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            ev_q       <= '0;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            state_q    <= StIdle;
            win_q      <= '0;
            tie_flag_q <= 1'b0;
            first_q    <= 1'b0;
            winrnd_q   <= 1'b0;
            right_q    <= 1'b0;
            tie_q      <= 1'b0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            lvl_q      <= lvl_d;
            ev_q       <= ev_d;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            state_q    <= state_d;
            win_q      <= win_d;
            tie_flag_q <= tie_flag_d;
            first_q    <= first_d;
            winrnd_q   <= winrnd_d;
            right_q    <= right_d;
            tie_q      <= tie_d;
        end
    end

    assign bus.winrnd = winrnd_q;
    assign bus.right  = right_q;
    assign bus.tie    = tie_q;
endmodule

// File: tb/tb_press_arbiter.sv
// Scenario bench for press_arbiter: expected result strobes are queued at stimulus time
// and matched by a monitor sampling on the falling edge.
module tb_press_arbiter;
    localparam int unsigned Deb = 4;
    localparam int unsigned Win = 3;
    // First clean press sampled at edge k -> result visible in the cycle after edge k + Lat.
    localparam int unsigned Lat = 2 + Deb + Win + 1;

    typedef struct {
        int unsigned cyc;
        bit          is_tie;
        bit          rgt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned bad = 0;
    int unsigned n_pulses = 0;
    exp_t        sb[$];

    press_arbiter_if bus ();

    press_arbiter #(
        .DEBOUNCE_CYCLES(Deb),
        .TIE_WINDOW     (Win)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && (bus.winrnd || bus.tie)) begin
            n_pulses++;
            checks++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result cyc=%0d winrnd=%b tie=%b right=%b, required no strobe",
                         cyc, bus.winrnd, bus.tie, bus.right);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc !== e.cyc || bus.tie !== e.is_tie || bus.winrnd !== !e.is_tie ||
                    bus.right !== e.rgt) begin
                    bad++;
                    $display("FAIL result cyc=%0d winrnd=%b tie=%b right=%b, required cyc=%0d winrnd=%b tie=%b right=%b",
                             cyc, bus.winrnd, bus.tie, bus.right, e.cyc, !e.is_tie, e.is_tie, e.rgt);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        step(1);
        bus.clr = 1'b0;
    endtask

    task automatic push_exp(input int unsigned c, input bit is_tie, input bit rgt);
        exp_t e;
        e.cyc    = c;
        e.is_tie = is_tie;
        e.rgt    = rgt;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        checks++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s missing results=%0d, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%b, required %b", name, act, req);
        end
    endtask

    task automatic check_quiet(input string name, input int unsigned n0);
        checks++;
        if (n_pulses !== n0) begin
            bad++;
            $display("FAIL %s strobes=%0d, required 0", name, n_pulses - n0);
        end
    endtask

    task automatic test_reset();
        int unsigned n0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check_bit("reset_winrnd", bus.winrnd, 1'b0);
        check_bit("reset_right", bus.right, 1'b0);
        check_bit("reset_tie", bus.tie, 1'b0);
        n0 = n_pulses;
        bus.pbl = 1'b1;
        bus.pbr = 1'b1;
        step(16);
        check_quiet("press_without_clr", n0);
        bus.pbl = 1'b0;
        bus.pbr = 1'b0;
        step(12);
    endtask

    task automatic test_left_win();
        pulse_clr();
        step(2);
        bus.pbl = 1'b1;
        push_exp(cyc + 1 + Lat, 1'b0, 1'b0);
        step(16);
        drain("left_win");
        check_bit("left_win_right_held", bus.right, 1'b0);
        bus.pbl = 1'b0;
        step(12);
    endtask

    task automatic test_bouncy_right();
        int unsigned n0;
        pulse_clr();
        step(2);
        for (int i = 0; i < 4; i++) begin
            bus.pbr = (i % 2 == 0);
            step(1);
        end
        bus.pbr = 1'b1;
        push_exp(cyc + 1 + Lat, 1'b0, 1'b1);
        step(16);
        drain("bouncy_right");
        check_bit("bouncy_right_held", bus.right, 1'b1);
        n0 = n_pulses;
        bus.pbl = 1'b1;
        step(16);
        check_quiet("press_after_result", n0);
        bus.pbl = 1'b0;
        bus.pbr = 1'b0;
        step(12);
        check_bit("right_still_held", bus.right, 1'b1);
    endtask

    task automatic test_ties();
        int unsigned offs[3] = '{0, 3, 4};
        for (int t = 0; t < 3; t++) begin
            int unsigned k;
            pulse_clr();
            step(2);
            bus.pbl = 1'b1;
            k = cyc + 1;
            if (offs[t] > 0) step(offs[t]);
            bus.pbr = 1'b1;
            push_exp(k + Lat, offs[t] <= Win, 1'b0);
            step(16);
            drain("tie_offset");
            bus.pbl = 1'b0;
            bus.pbr = 1'b0;
            step(12);
        end
    endtask

    task automatic test_held_and_clear();
        int unsigned n0;
        bus.pbl = 1'b1;
        step(14);
        pulse_clr();
        n0 = n_pulses;
        step(16);
        check_quiet("held_before_clr", n0);
        bus.pbl = 1'b0;
        step(12);
        bus.pbl = 1'b1;
        push_exp(cyc + 1 + Lat, 1'b0, 1'b0);
        step(16);
        drain("repress_win");
        bus.pbl = 1'b0;
        step(12);

        pulse_clr();
        step(2);
        bus.pbl = 1'b1;
        n0 = n_pulses;
        step(8);
        pulse_clr();
        step(16);
        check_quiet("clr_in_window", n0);
        bus.pbl = 1'b0;
        step(12);
        bus.pbl = 1'b1;
        push_exp(cyc + 1 + Lat, 1'b0, 1'b0);
        step(16);
        drain("rearmed_after_clr");
        bus.pbl = 1'b0;
        step(12);
    endtask

    task automatic test_rst_window();
        int unsigned n0;
        pulse_clr();
        step(2);
        bus.pbr = 1'b1;
        push_exp(cyc + 1 + Lat, 1'b0, 1'b1);
        step(16);
        drain("right_win_pre_rst");
        bus.pbr = 1'b0;
        step(12);
        check_bit("right_before_rst", bus.right, 1'b1);

        pulse_clr();
        step(2);
        bus.pbl = 1'b1;
        step(8);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_bit("rst_mid_winrnd", bus.winrnd, 1'b0);
        check_bit("rst_mid_right", bus.right, 1'b0);
        check_bit("rst_mid_tie", bus.tie, 1'b0);
        n0 = n_pulses;
        step(16);
        check_quiet("rst_in_window", n0);
        bus.pbl = 1'b0;
        step(12);
    endtask

    initial begin
        bus.pbl = 1'b0;
        bus.pbr = 1'b0;
        bus.clr = 1'b0;
        test_reset();
        test_left_win();
        test_bouncy_right();
        test_ties();
        test_held_and_clear();
        test_rst_window();
        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end
endmodule

// File: doc/press_arbiter.md
# press_arbiter

Input front end of the tug-of-war round logic. It synchronizes and debounces the two raw pushbuttons (`pbl`, `pbr`) and decides who pressed first once a round is armed. It then emits a single result strobe (`winrnd` with `right`, or `tie`) that the scorer consumes. Arming comes from the `clr` pulse issued by the clear/LED controller. Between results and the next `clr`, all presses are ignored.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a debounced level changes. Must be ≥1.
- `TIE_WINDOW`, default 8: number of cycles after the first press during which the opposing press still counts as a tie. 0 means only a same-cycle press is a tie.

Ports:
- `clk`, in, 1: single system clock (the divided game clock); all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `pbl`, in, 1: raw left pushbutton, asynchronous, active-high, bouncy.
- `pbr`, in, 1: raw right pushbutton, asynchronous, active-high, bouncy.
- `clr`, in, 1: one-cycle arm pulse from the clear/LED controller. Starts a new round.
- `winrnd`, out, 1: one-cycle pulse, a single player won the round.
- `right`, out, 1: winner side, 1 = right, 0 = left. Updated in the `winrnd` cycle and held until the next result.
- `tie`, out, 1: one-cycle pulse, both players pressed within the window.

## Operation
Conditioning, identical per button:
- A 2-flop synchronizer feeds a debouncer.
- The debouncer holds a debounced level and a counter of width clog2(DEBOUNCE_CYCLES+1).
- While the synchronized input differs from the debounced level, the counter increments.
- When the counter reaches DEBOUNCE_CYCLES, the level flips and the counter clears.
- Any cycle where the input equals the level also clears the counter.
- A press event is a registered one-cycle pulse on a debounced 0→1 transition. Releases generate nothing.
- Holding a button produces exactly one press event.

State machine: IDLE, ARMED, WINDOW, RESULT.
- **IDLE:** all press events are ignored. `clr` → ARMED.
- **ARMED:**
  - Left event only → WINDOW, first = left, window counter = 0.
  - Right event only → WINDOW, first = right.
  - Both in the same cycle → WINDOW with the tie flag set.
- **WINDOW:**
  - The window counter increments each cycle.
  - An event from the opposite side sets the tie flag. A repeat event from the same side has no effect.
  - When the counter equals TIE_WINDOW → RESULT.
- **RESULT** (one cycle):
  - Tie flag set: `tie`=1, `winrnd`=0, `right`=0.
  - Otherwise: `winrnd`=1, `right`=first.
  - Next state is IDLE.
- **`clr` in any state:** → ARMED. Any pending window, flag and result is discarded; `clr` takes priority over press events in the same cycle.
- **Early presses:** a button already held down when `clr` arrives produces no new event. It must be released and pressed again. There is no foul penalty.

Outputs are registered, with no combinational path from inputs. `winrnd` and `tie` are never high together.

## Timing
- **Reset:**
  - `winrnd`=0, `right`=0, `tie`=0.
  - State IDLE.
  - Synchronizers, debounced levels, counters and the tie flag all 0.
- **Press event latency:** pin first sampled high at edge k with no bounce → press event high in the cycle after edge k+2+DEBOUNCE_CYCLES.
- **Result latency:** first press event registered in ARMED at edge e → WINDOW entered at e. The result pulse is high in the cycle after edge e+TIE_WINDOW+1.
- **Tie boundary:** the opposing event counts as a tie if it occurs in the ARMED→WINDOW cycle or any WINDOW cycle up to and including the one where the counter equals TIE_WINDOW. Later events are ignored.
- **Bounce:** a glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
- **`rst` mid-round:** returns to the reset state on the next edge; no result is emitted.

## Test plan
Use DEBOUNCE_CYCLES=4, TIE_WINDOW=3.
- **Reset values:** assert `rst` 2 cycles → all outputs 0. Presses with no `clr` → no `winrnd` or `tie`.
- **Clean left win:** `clr`, then `pbl` held high from edge k → `winrnd`=1 and `right`=0 for exactly one cycle, after edge k+6+4. `right` stays 0 afterward.
- **Bouncy right win:**
  - `clr`, then `pbr` toggles 1,0,1,0 per cycle, then stays high.
  - Required: single `winrnd` with `right`=1, timed from the start of the stable run.
  - `pbl` pressed afterward without a new `clr` → no output.
- **Ties:**
  - Both pressed the same cycle → `tie`=1, `winrnd`=0.
  - `pbr` 3 cycles after `pbl` → `tie`.
  - `pbr` 4 cycles after `pbl` → `winrnd`, `right`=0.
- **Held-button and clear cases:**
  - `pbl` held before `clr` → no event. Release and re-press → win.
  - `clr` during WINDOW → window discarded and no result.
  - `rst` during WINDOW → no result, outputs 0.
